// File: rtl/mux8_sync.sv
// rtl/mux8_sync.sv - registered 8-to-1 bit selector with active-low enable
// Optional MUX8_SYNC_PIPE2_EN adds an input register stage (latency 2).
module mux8_sync #(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] addr,
  input  logic [7:0] m_input,
  output logic       m_output,
  output logic       m_output_n,
  output logic       valid
);

  logic       en_s;
  logic [2:0] addr_s;
  logic [7:0] data_s;
  logic       sel_bit;

`ifdef MUX8_SYNC_PIPE2_EN
  logic       en_q;
  logic [2:0] addr_q;
  logic [7:0] data_q;

  // The staged enable resets to disabled so the output stage stays idle
  // until a real enabled sample has passed through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b1;
      addr_q <= 3'd0;
      data_q <= 8'd0;
    end else begin
      en_q   <= en;
      addr_q <= addr;
      data_q <= m_input;
    end
  end

  assign en_s   = en_q;
  assign addr_s = addr_q;
  assign data_s = data_q;
`else
  assign en_s   = en;
  assign addr_s = addr;
  assign data_s = m_input;
`endif

  // Indexing keeps unselected bits (even X) out of the result.
  always_comb begin
    sel_bit = data_s[addr_s];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_output   <= IDLE_VAL;
      m_output_n <= ~IDLE_VAL;
      valid      <= 1'b0;
    end else if (en_s) begin
      m_output   <= IDLE_VAL;
      m_output_n <= ~IDLE_VAL;
      valid      <= 1'b0;
    end else begin
      m_output   <= sel_bit;
      m_output_n <= ~sel_bit;
      valid      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux8_sync.sv
// tb/tb_mux8_sync.sv - directed-vector bench for mux8_sync
// Expected triples are {valid, m_output, m_output_n}, delayed by the build latency.
module tb_mux8_sync;

`ifdef MUX8_SYNC_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2:0] E_IDLE = 3'b001;
  localparam logic [2:0] E_ONE  = 3'b110;
  localparam logic [2:0] E_ZERO = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] m_input = 8'd0;
  logic       m_output;
  logic       m_output_n;
  logic       valid;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] pipe [LAT];

  mux8_sync dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .addr       (addr),
    .m_input    (m_input),
    .m_output   (m_output),
    .m_output_n (m_output_n),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {valid,out,out_n}=%b expected %b", tag, got, exp);
    end
  endtask

  // Apply one vector, clock it in, then compare against the hand-given
  // expectation as it emerges after LAT edges (reset flushes everything).
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [2:0] a, input logic [7:0] d,
                      input logic [2:0] vexp);
    rst_n   = r;
    en      = e;
    addr    = a;
    m_input = d;
    @(posedge clk);
    #1;
    if (!r) begin
      for (int i = 0; i < LAT; i++) pipe[i] = E_IDLE;
    end else begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = vexp;
    end
    check(tag, {valid, m_output, m_output_n}, pipe[LAT-1]);
  endtask

  initial begin
    logic [7:0] xword;
    for (int i = 0; i < LAT; i++) pipe[i] = E_IDLE;

    for (int i = 0; i < 3; i++)
      step($sformatf("reset%0d", i), 1'b0, 1'b0, 3'd7, 8'hFF, E_IDLE);
    step("release", 1'b1, 1'b0, 3'd7, 8'hFF, E_ONE);

    for (int k = 0; k < 8; k++)
      step($sformatf("disabled_a%0d", k), 1'b1, 1'b1, 3'(k), 8'hFF, E_IDLE);

    for (int k = 0; k < 8; k++)
      step($sformatf("onehot_a%0d", k), 1'b1, 1'b0, 3'(k), 8'(1 << k), E_ONE);
    for (int k = 0; k < 8; k++)
      step($sformatf("onecold_a%0d", k), 1'b1, 1'b0, 3'(k), ~8'(1 << k), E_ZERO);

    for (int i = 0; i < 6; i++)
      step($sformatf("toggle%0d", i), 1'b1, 1'b0, 3'd3,
           (i % 2 == 0) ? 8'h08 : 8'hF7, (i % 2 == 0) ? E_ONE : E_ZERO);

    step("en_lo", 1'b1, 1'b0, 3'd7, 8'h80, E_ONE);
    step("en_hi", 1'b1, 1'b1, 3'd7, 8'h80, E_IDLE);
    step("en_lo2", 1'b1, 1'b0, 3'd7, 8'h80, E_ONE);
    step("pre_rst", 1'b1, 1'b0, 3'd7, 8'h80, E_ONE);
    step("mid_rst", 1'b0, 1'b0, 3'd7, 8'h80, E_IDLE);
    step("post_rst", 1'b1, 1'b0, 3'd7, 8'h80, E_ONE);
    step("post_rst2", 1'b1, 1'b0, 3'd0, 8'h80, E_ZERO);

    xword = 8'bxxxx_1xxx;
    step("x_unsel_1", 1'b1, 1'b0, 3'd3, xword, E_ONE);
    xword = 8'b0xxx_xxxx;
    step("x_unsel_0", 1'b1, 1'b0, 3'd7, xword, E_ZERO);
    step("lsb", 1'b1, 1'b0, 3'd0, 8'h01, E_ONE);
    step("msb_vs_lsb", 1'b1, 1'b0, 3'd7, 8'h01, E_ZERO);

    for (int i = 0; i < LAT + 1; i++)
      step($sformatf("flush%0d", i), 1'b1, 1'b1, 3'd0, 8'hFF, E_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
